ps2_host_rx: RTL



---
 rtl/ps2_host_rx_pkg.sv | 20 ++
 rtl/ps2_host_rx_if.sv | 34 +++
 rtl/ps2_host_rx_fifo.sv | 49 ++++
 rtl/ps2_host_rx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ps2_host_rx_pkg.sv
// Shared types and frame constants for the PS/2 host receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam logic PS2_START     = 1'b0;
    localparam logic PS2_STOP      = 1'b1;
    localparam int   PS2_DATA_BITS = 8;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_rx_if.sv
// Byte stream and error-pulse bundle between the PS/2 receiver and core logic.
interface ps2_host_rx_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       timeout_err;
    logic       overflow;

    // Receiver side: produces bytes and error pulses, accepts ready.
    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output timeout_err,
        output overflow,
        input  rx_ready
    );

    // Consumer side.
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  timeout_err,
        input  overflow,
        output rx_ready
    );

endinterface

// File: rtl/ps2_host_rx_fifo.sv
// Small synchronous FIFO with wrap-around pointers carrying an extra lap bit.
module ps2_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    // Storage is not reset; the head reads as zero whenever nothing is queued.
    assign dout    = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_host_rx.sv
// PS/2 host receiver: synchronise and deglitch the PS/2 lines, deframe
// start/data/parity/stop, and queue good bytes behind a valid/ready port.
module ps2_host_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 20000,
    parameter int FIFO_BITS  = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    ps2_host_rx_if.master rx
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    // Index 0 is the PS/2 clock line, index 1 the data line.
    logic [1:0]            sync_p0;
    logic [1:0]            sync_p1;
    logic [1:0]            line_f;
    logic [1:0][FLT_W-1:0] flt_cnt;
    logic                  clk_f_d;
    logic                  fall;
    logic                  bit_in;

    rx_state_t                state, state_n;
    logic [2:0]               bit_cnt, bit_cnt_n;
    logic [WD_W-1:0]          wd_cnt, wd_cnt_n;
    logic [PS2_DATA_BITS-1:0] shreg, shreg_n;
    logic                     par, par_n;
    logic                     push_req;
    logic                     perr_n, ferr_n, terr_n, ovf_n;
    logic                     perr_q, ferr_q, terr_q, ovf_q;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     pop;
    logic [7:0]               fifo_dout;

    assign fall   = clk_f_d & ~line_f[0];
    assign bit_in = line_f[1];
    assign pop    = rx.rx_valid && rx.rx_ready;

    // Two-flop synchroniser followed by a run-length filter on each line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
            line_f  <= '1;
            flt_cnt <= '0;
            clk_f_d <= 1'b1;
        end else begin
            sync_p0 <= {ps2_data, ps2_clk};
            sync_p1 <= sync_p0;
            clk_f_d <= line_f[0];
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == line_f[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FLT_W'(FILTER_LEN - 1)) begin
                    line_f[i]  <= sync_p1[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Frame FSM state, counters and one-cycle status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            wd_cnt  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            terr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            wd_cnt  <= wd_cnt_n;
            perr_q  <= perr_n;
            ferr_q  <= ferr_n;
            terr_q  <= terr_n;
            ovf_q   <= ovf_n;
        end
    end

    // Frame data path; contents only matter once a full frame is in.
    always_ff @(posedge clk) begin
        shreg <= shreg_n;
        par   <= par_n;
    end

    // Next-state logic, frame checking and watchdog.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par;
        push_req  = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        terr_n    = 1'b0;
        wd_cnt_n  = (state == ST_IDLE || fall) ? '0 : wd_cnt + 1'b1;

        case (state)
            ST_IDLE: begin
                // A high level at a falling edge is a spurious start.
                if (fall && bit_in == PS2_START) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shreg_n   = {bit_in, shreg[PS2_DATA_BITS-1:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state_n = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_n   = bit_in;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_n = ST_IDLE;
                    if (bit_in != PS2_STOP)             ferr_n   = 1'b1;
                    else if (par != odd_parity(shreg))  perr_n   = 1'b1;
                    else                                push_req = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // A stalled device abandons the partial frame.
        if (state != ST_IDLE && !fall && wd_cnt == WD_W'(TIMEOUT)) begin
            state_n  = ST_IDLE;
            shreg_n  = '0;
            wd_cnt_n = '0;
            terr_n   = 1'b1;
        end

        ovf_n = push_req && fifo_full && !pop;
    end

    ps2_rx_fifo #(
        .DATA_W (PS2_DATA_BITS),
        .ADDR_W (FIFO_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_req),
        .din     (shreg),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rx.rx_data     = fifo_dout;
    assign rx.rx_valid    = !fifo_empty;
    assign rx.parity_err  = perr_q;
    assign rx.frame_err   = ferr_q;
    assign rx.timeout_err = terr_q;
    assign rx.overflow    = ovf_q;

endmodule
